// File: rtl/led_display_row_fetch_pkg.sv
// Shared types and defaults for the LED display row loader.
package led_display_package;

  localparam int DEFAULT_ROW_WORDS  = 12;
  localparam int DEFAULT_ROW_COUNT  = 16;
  localparam int DEFAULT_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } fetch_state_t;

  function automatic int row_width(input int word_w, input int row_words);
    return word_w * row_words;
  endfunction

endpackage

// File: rtl/led_display_rd_pipe.sv
// RAM read-latency delay line: carries each strobe and its word index forward
// so the capture enable lines up exactly with the returning read data.
module led_display_rd_pipe #(
  parameter int RD_LATENCY = 2,
  parameter int IDX_W      = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             strobe_in,
  input  logic [IDX_W-1:0] index_in,
  output logic             capture_out,
  output logic [IDX_W-1:0] capture_index_out
);

  logic [RD_LATENCY-1:0] vld_reg;
  logic [IDX_W-1:0]      idx_reg [RD_LATENCY];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      vld_reg <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_reg[i] <= '0;
    end else begin
      vld_reg[0] <= strobe_in;
      idx_reg[0] <= index_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        idx_reg[i] <= idx_reg[i-1];
      end
    end
  end

  assign capture_out       = vld_reg[RD_LATENCY-1];
  assign capture_index_out = idx_reg[RD_LATENCY-1];

endmodule

// File: rtl/led_display_row_fetch.sv
// Row loader: reads ROW_WORDS RAM words per scan row and presents the row over valid/ready.
// Define LED_ROW_FETCH_PREFETCH_EN to fetch the next row while the current one is held.
module led_display_row_fetch
  import led_display_package::*;
#(
  parameter int WORD_W     = 32,
  parameter int ROW_WORDS  = DEFAULT_ROW_WORDS,
  parameter int ROW_COUNT  = DEFAULT_ROW_COUNT,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int ADDR_W     = 32
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   enable_in,
  input  logic [ADDR_W-1:0]                      frame_base_in,
  output logic                                   ram_rd_en_out,
  output logic [ADDR_W-1:0]                      ram_address_out,
  input  logic [WORD_W-1:0]                      ram_rdata_in,
  output logic [row_width(WORD_W,ROW_WORDS)-1:0] row_out,
  output logic [$clog2(ROW_COUNT)-1:0]           row_address_out,
  output logic                                   row_valid_out,
  input  logic                                   row_ready_in,
  output logic                                   frame_start_out,
  output logic                                   frame_end_out
);

  localparam int ROW_BITS = row_width(WORD_W, ROW_WORDS);
  localparam int IDX_W    = $clog2(ROW_WORDS);
  localparam int RA_W     = $clog2(ROW_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_WORDS - 1);
  localparam logic [RA_W-1:0]  LAST_ROW = RA_W'(ROW_COUNT - 1);
`ifdef LED_ROW_FETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  fetch_state_t        state_reg, state_next;
  logic [IDX_W-1:0]    word_cnt_reg;
  logic [RA_W-1:0]     fetch_row_reg, row_addr_reg;
  logic [ADDR_W-1:0]   base_reg, addr_reg, base_sel, start_addr;
  logic [ROW_BITS-1:0] fill_reg, fill_next, row_reg;
  logic                valid_reg, start_reg, end_reg;
  logic                capture;
  logic [IDX_W-1:0]    capture_idx;
  logic                fill_done, transfer, can_load, issue_start, load_row, row_advance;

  led_display_rd_pipe #(
    .RD_LATENCY(RD_LATENCY),
    .IDX_W     (IDX_W)
  ) u_rd_pipe (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .strobe_in        (ram_rd_en_out),
    .index_in         (word_cnt_reg),
    .capture_out      (capture),
    .capture_index_out(capture_idx)
  );

  assign transfer   = valid_reg & row_ready_in;
  assign fill_done  = capture & (capture_idx == LAST_IDX);
  assign can_load   = !valid_reg || transfer;
  // Row 0 uses the live base so the latch and the first address agree in the same cycle.
  assign base_sel   = (fetch_row_reg == '0) ? frame_base_in : base_reg;
  assign start_addr = base_sel + ADDR_W'(fetch_row_reg) * ADDR_W'(ROW_WORDS);

  // Word k sits at the MSB end for k=0; the returning word is merged in flight so
  // the final word can be handed to the presented row in the same cycle it lands.
  for (genvar gi = 0; gi < ROW_WORDS; gi++) begin : g_word
    localparam int HI = (ROW_WORDS - gi) * WORD_W - 1;
    assign fill_next[HI -: WORD_W] = (capture && capture_idx == IDX_W'(gi))
                                     ? ram_rdata_in : fill_reg[HI -: WORD_W];
  end

  always_comb begin
    state_next  = state_reg;
    issue_start = 1'b0;
    load_row    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable_in && (PREFETCH || !valid_reg)) begin
          state_next  = ISSUE;
          issue_start = 1'b1;
        end
      end
      ISSUE: begin
        if (word_cnt_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        if (fill_done) begin
          if (!PREFETCH) begin
            load_row   = 1'b1;
            state_next = HOLD;
          end else if (can_load) begin
            load_row   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // Prefetch: completed fill waits here for the presented slot to free up.
        if (PREFETCH) begin
          if (can_load) begin
            load_row   = 1'b1;
            state_next = IDLE;
          end
        end else if (transfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign row_advance = PREFETCH ? load_row : ((state_reg == HOLD) && transfer);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      fetch_row_reg <= '0;
      base_reg      <= '0;
      addr_reg      <= '0;
      fill_reg      <= '0;
      row_reg       <= '0;
      row_addr_reg  <= '0;
      valid_reg     <= 1'b0;
      start_reg     <= 1'b0;
      end_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (issue_start) begin
        word_cnt_reg <= '0;
        addr_reg     <= start_addr;
        if (fetch_row_reg == '0) base_reg <= frame_base_in;
      end else if (state_reg == ISSUE) begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
        addr_reg     <= addr_reg + 1'b1;
      end
      if (capture) fill_reg <= fill_next;
      if (load_row) begin
        row_reg      <= fill_next;
        row_addr_reg <= fetch_row_reg;
        start_reg    <= (fetch_row_reg == '0);
        end_reg      <= (fetch_row_reg == LAST_ROW);
      end
      if (load_row)      valid_reg <= 1'b1;
      else if (transfer) valid_reg <= 1'b0;
      if (row_advance) fetch_row_reg <= fetch_row_reg + 1'b1;
    end
  end

  assign ram_rd_en_out   = (state_reg == ISSUE);
  assign ram_address_out = addr_reg;
  assign row_out         = row_reg;
  assign row_address_out = row_addr_reg;
  assign row_valid_out   = valid_reg;
  assign frame_start_out = valid_reg & start_reg;
  assign frame_end_out   = valid_reg & end_reg;

endmodule

// File: tb/tb_led_display_row_fetch.sv
// Directed bench for led_display_row_fetch: default geometry (A) and a small
// 4-word / 2-row / latency-5 geometry (B), each with a data=address RAM model.
module tb_led_display_row_fetch;

  localparam int A_RW = 12, A_RC = 16, A_L = 2;
  localparam int B_RW = 4,  B_RC = 2,  B_L = 5;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic reset_in = 1'b1;

  logic         en_a = 1'b0, ready_a = 1'b0, rd_a, valid_a, fs_a, fe_a;
  logic [31:0]  base_a = '0, addr_a, rdata_a;
  logic [383:0] row_a;
  logic [3:0]   raddr_a;

  logic         en_b = 1'b0, ready_b = 1'b0, rd_b, valid_b, fs_b, fe_b;
  logic [31:0]  base_b = '0, addr_b;
  logic [15:0]  rdata_b;
  logic [63:0]  row_b;
  logic [0:0]   raddr_b;

  led_display_row_fetch #(.WORD_W(32), .ROW_WORDS(A_RW), .ROW_COUNT(A_RC),
                          .RD_LATENCY(A_L), .ADDR_W(32)) u_dut_a (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(en_a), .frame_base_in(base_a),
    .ram_rd_en_out(rd_a), .ram_address_out(addr_a), .ram_rdata_in(rdata_a),
    .row_out(row_a), .row_address_out(raddr_a), .row_valid_out(valid_a),
    .row_ready_in(ready_a), .frame_start_out(fs_a), .frame_end_out(fe_a));

  led_display_row_fetch #(.WORD_W(16), .ROW_WORDS(B_RW), .ROW_COUNT(B_RC),
                          .RD_LATENCY(B_L), .ADDR_W(32)) u_dut_b (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(en_b), .frame_base_in(base_b),
    .ram_rd_en_out(rd_b), .ram_address_out(addr_b), .ram_rdata_in(rdata_b),
    .row_out(row_b), .row_address_out(raddr_b), .row_valid_out(valid_b),
    .row_ready_in(ready_b), .frame_start_out(fs_b), .frame_end_out(fe_b));

  // RAM models: return the strobed address after the read latency, junk otherwise.
  logic [31:0] pipe_a [A_L];
  logic [15:0] pipe_b [B_L];
  always @(posedge clk_in) begin
    pipe_a[0] <= rd_a ? addr_a : 32'hDEAD_BEEF;
    for (int i = 1; i < A_L; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= rd_b ? addr_b[15:0] : 16'hDEAD;
    for (int i = 1; i < B_L; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign rdata_a = pipe_a[A_L-1];
  assign rdata_b = pipe_b[B_L-1];

  // Strobe counters; row0_addr_a holds the first address of each 16th burst (row 0).
  int          strobes_a = 0, strobes_b = 0, bursts_a = 0;
  logic        rd_a_d = 1'b0;
  logic [31:0] row0_addr_a = '0;
  always @(posedge clk_in) begin
    rd_a_d <= rd_a;
    if (rd_a) strobes_a <= strobes_a + 1;
    if (rd_b) strobes_b <= strobes_b + 1;
    if (reset_in) bursts_a <= 0;
    else if (rd_a && !rd_a_d) begin
      if (bursts_a % A_RC == 0) row0_addr_a <= addr_a;
      bursts_a <= bursts_a + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [383:0] exp_row_a(input logic [31:0] first);
    logic [383:0] r;
    r = '0;
    for (int k = 0; k < A_RW; k++) r[(A_RW-k)*32-1 -: 32] = first + 32'(k);
    return r;
  endfunction

  function automatic logic [63:0] exp_row_b(input logic [15:0] first);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < B_RW; k++) r[(B_RW-k)*16-1 -: 16] = first + 16'(k);
    return r;
  endfunction

  task automatic wait_valid_a(input string tag, output int n);
    n = 0;
    while (!valid_a && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_timeout"}, {383'd0, !valid_a}, '0);
  endtask

  task automatic collect_a(input int row, input logic [31:0] first, input int exp_lat);
    int lat;
    wait_valid_a($sformatf("a_row%0d_wait", row), lat);
    if (exp_lat >= 0) check($sformatf("a_row%0d_latency", row), lat, exp_lat);
    check($sformatf("a_row%0d_addr", row), raddr_a, row);
    check($sformatf("a_row%0d_data", row), row_a, exp_row_a(first));
    check($sformatf("a_row%0d_fstart", row), fs_a, row == 0);
    check($sformatf("a_row%0d_fend", row), fe_a, row == A_RC - 1);
    @(negedge clk_in);
  endtask

  task automatic collect_b(input int row, input logic [15:0] first, input int exp_lat,
                           input int exp_strobes);
    int n;
    n = 0;
    while (!valid_b && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    if (exp_lat >= 0) check($sformatf("b_row%0d_latency", row), n, exp_lat);
    check($sformatf("b_row%0d_addr", row), raddr_b, row);
    check($sformatf("b_row%0d_data", row), row_b, exp_row_b(first));
    check($sformatf("b_row%0d_fstart", row), fs_b, row == 0);
    check($sformatf("b_row%0d_fend", row), fe_b, row == B_RC - 1);
`ifndef LED_ROW_FETCH_PREFETCH_EN
    check($sformatf("b_row%0d_strobes", row), strobes_b, exp_strobes);
`else
    if (exp_strobes < 0) check("b_strobes_unreachable", strobes_b, exp_strobes);
`endif
    @(negedge clk_in);
  endtask

  initial begin
    int n, s0, bad;
    repeat (3) @(negedge clk_in);
    check("rst_rd_en", rd_a, 0);
    check("rst_address", addr_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_row", row_a, 0);
    check("rst_row_addr", raddr_a, 0);
    check("rst_markers", {fs_a, fe_a}, 0);
    check("rst_b_valid", valid_b, 0);
    check("rst_b_row", row_b, 0);

    reset_in = 1'b0;
    base_a   = 32'h100;
    ready_a  = 1'b1;
    @(negedge clk_in);
    en_a = 1'b1;
    collect_a(0, 32'h100, 15);
    collect_a(1, 32'h10C, -1);
    collect_a(2, 32'h118, -1);

    // Row 3 held unaccepted for 50 cycles.
    ready_a = 1'b0;
    wait_valid_a("a_row3_wait", n);
    check("a_row3_addr", raddr_a, 3);
    check("a_row3_data", row_a, exp_row_a(32'h124));
    s0  = strobes_a;
    bad = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (!valid_a || row_a !== exp_row_a(32'h124) || raddr_a !== 4'd3) bad++;
    end
    check("a_row3_stable", bad, 0);
`ifndef LED_ROW_FETCH_PREFETCH_EN
    check("a_row3_no_strobes", strobes_a - s0, 0);
`endif
    ready_a = 1'b1;
    @(negedge clk_in);
`ifndef LED_ROW_FETCH_PREFETCH_EN
    check("a_row3_valid_drop", valid_a, 0);
`endif

    for (int r = 4; r < A_RC; r++) begin
      collect_a(r, 32'h100 + 32'(r * A_RW), -1);
      if (r == 5) base_a = 32'h400;
    end
    collect_a(0, 32'h400, -1);
    check("a_frame2_first_addr", row0_addr_a, 32'h400);

    // Reset while the row-1 fetch is draining.
    n = 0;
    while (!rd_a && n < 300) begin @(negedge clk_in); n++; end
    while (rd_a && n < 300) begin @(negedge clk_in); n++; end
    check("a_drain_timeout", {383'd0, n >= 300}, '0);
    reset_in = 1'b1;
    en_a     = 1'b0;
    #1;
    check("drain_rst_rd_en", rd_a, 0);
    check("drain_rst_valid", valid_a, 0);
    check("drain_rst_row", row_a, 0);
    check("drain_rst_addr", addr_a, 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    base_a   = 32'h200;
    @(negedge clk_in);
    check("post_rst_idle_valid", valid_a, 0);
    en_a = 1'b1;
    collect_a(0, 32'h200, 15);
    check("post_rst_first_addr", row0_addr_a, 32'h200);
    en_a = 1'b0;

    // Small geometry: 4 words, 2 rows, latency 5, 16-bit words.
    base_b  = 32'h40;
    ready_b = 1'b1;
    @(negedge clk_in);
    en_b = 1'b1;
    collect_b(0, 16'h40, 10, 4);
    collect_b(1, 16'h44, -1, 8);
    collect_b(0, 16'h40, -1, 12);
    en_b = 1'b0;

`ifdef LED_ROW_FETCH_PREFETCH_EN
    // Ready pulsed every 20 cycles: next row fetched during hold, no valid gaps.
    reset_in = 1'b1;
    ready_a  = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b0;
    base_a   = 32'h100;
    @(negedge clk_in);
    en_a = 1'b1;
    wait_valid_a("pf_first_wait", n);
    for (int r = 0; r < 5; r++) begin
      check($sformatf("pf_row%0d_addr", r), raddr_a, r);
      check($sformatf("pf_row%0d_data", r), row_a, exp_row_a(32'h100 + 32'(r * A_RW)));
      s0  = strobes_a;
      bad = 0;
      repeat (19) begin
        @(negedge clk_in);
        if (!valid_a) bad++;
      end
      ready_a = 1'b1;
      @(negedge clk_in);
      ready_a = 1'b0;
      if (!valid_a) bad++;
      check($sformatf("pf_row%0d_gaps", r), bad, 0);
      check($sformatf("pf_row%0d_hold_strobes", r), strobes_a - s0, A_RW);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
